// File: rtl/gol_gen_sequencer_if.sv
// Board-store access bundle between the generation sequencer and the
// neighbour decoder / row buffers: three read row addresses, the decoded
// new row coming back, and the write port into the inactive buffer.
interface gol_gen_sequencer_if #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3
);
  logic [REGBITS-1:0] rd_addr1;
  logic [REGBITS-1:0] rd_addr2;
  logic [REGBITS-1:0] rd_addr3;
  logic [WIDTH-1:0]   new_row;
  logic               wr_en;
  logic [REGBITS-1:0] wr_addr;
  logic [WIDTH-1:0]   wd;

  // Sequencer side: drives addresses and the write port, consumes new_row.
  modport master (
    output rd_addr1, rd_addr2, rd_addr3, wr_en, wr_addr, wd,
    input  new_row
  );

  // Board-store / decoder side.
  modport slave (
    input  rd_addr1, rd_addr2, rd_addr3, wr_en, wr_addr, wd,
    output new_row
  );
endinterface

// File: rtl/gol_gen_sequencer.sv
// Game-of-Life generation sequencer. Walks every row r of the board with its
// toroidal neighbours (r-1, r, r+1) through the external decoder, writes each
// decoded row into the inactive buffer, then flips the ping-pong bank and
// bumps the generation counter. Supports free-run, single-step and a
// programmable idle gap between generations.
module gol_gen_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int PERW    = 16,
  parameter int CNTW    = 16
) (
  input  logic                 ph1,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 step,
  input  logic [PERW-1:0]      period,
  gol_gen_sequencer_if.master  board,
  output logic                 bank,
  output logic                 busy,
  output logic                 gen_done,
  output logic [CNTW-1:0]      gen_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2,
    WAIT   = 2'd3
  } state_t;

  // Row counter wraps naturally at 2**REGBITS, so the last row is all ones.
  localparam logic [REGBITS-1:0] LAST_ROW = '1;

  state_t             state_reg, state_next;
  logic [REGBITS-1:0] row_reg,   row_next;
  logic [PERW-1:0]    wait_reg,  wait_next;
  logic               bank_reg,  bank_next;
  logic [CNTW-1:0]    count_reg, count_next;
  logic [WIDTH-1:0]   row_data;

  // State and datapath registers; asynchronous active-low reset.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      wait_reg  <= '0;
      bank_reg  <= 1'b0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      wait_reg  <= wait_next;
      bank_reg  <= bank_next;
      count_reg <= count_next;
    end
  end

  // Next-state logic: row walk, commit bookkeeping and inter-generation gap.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    wait_next  = wait_reg;
    bank_next  = bank_reg;
    count_next = count_reg;

    case (state_reg)
      IDLE: begin
        row_next = '0;
        // run has priority; step only matters when run is low.
        if (run || step) begin
          state_next = EVAL;
        end
      end

      EVAL: begin
        // A started generation always runs to completion, regardless of run.
        if (row_reg == LAST_ROW) begin
          row_next   = '0;
          state_next = COMMIT;
        end else begin
          row_next = row_reg + 1'b1;
        end
      end

      COMMIT: begin
        bank_next  = ~bank_reg;
        count_next = count_reg + 1'b1;
        wait_next  = period;
        if (!run) begin
          state_next = IDLE;
        end else if (period == '0) begin
          state_next = EVAL;
        end else begin
          state_next = WAIT;
        end
      end

      WAIT: begin
        // Loaded with period in COMMIT, so WAIT lasts exactly period cycles.
        if (!run) begin
          wait_next  = '0;
          state_next = IDLE;
        end else if (wait_reg == {{(PERW-1){1'b0}}, 1'b1}) begin
          wait_next  = '0;
          state_next = EVAL;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        row_next   = '0;
      end
    endcase
  end

  // Neighbour addresses wrap modulo the row count through natural overflow.
  assign board.rd_addr1 = row_reg - 1'b1;
  assign board.rd_addr2 = row_reg;
  assign board.rd_addr3 = row_reg + 1'b1;
  assign board.wr_addr  = row_reg;
  assign board.wr_en    = (state_reg == EVAL);

  // The decoder result is written back in the same cycle it is addressed.
  assign row_data = board.new_row;
  assign board.wd = row_data;

  assign bank      = bank_reg;
  assign busy      = (state_reg != IDLE);
  assign gen_done  = (state_reg == COMMIT);
  assign gen_count = count_reg;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Directed bench for gol_gen_sequencer: a per-cycle vector table for a single
// step, plus hand-written sequences for free-run cadence, run drop mid-EVAL,
// asynchronous reset mid-run and counter wrap on a narrow-counter build.
module tb_gol_gen_sequencer;

  logic        ph1;
  logic        reset;
  logic        run;
  logic        step;
  logic [15:0] period;
  logic        bank;
  logic        busy;
  logic        gen_done;
  logic [15:0] gen_count;

  // Narrow-counter instance for the wrap check.
  logic        run2;
  logic        step2;
  logic [15:0] period2;
  logic        bank2;
  logic        busy2;
  logic        gen_done2;
  logic [3:0]  gen_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the architectural counters of the main instance.
  logic        exp_bank;
  logic [15:0] exp_count;

  gol_gen_sequencer_if #(.WIDTH(8), .REGBITS(3)) brd ();
  gol_gen_sequencer_if #(.WIDTH(8), .REGBITS(3)) brd2 ();

  gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .PERW(16), .CNTW(16)) dut (
    .ph1(ph1), .reset(reset), .run(run), .step(step), .period(period),
    .board(brd.master), .bank(bank), .busy(busy), .gen_done(gen_done),
    .gen_count(gen_count)
  );

  gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .PERW(16), .CNTW(4)) dut4 (
    .ph1(ph1), .reset(reset), .run(run2), .step(step2), .period(period2),
    .board(brd2.master), .bank(bank2), .busy(busy2), .gen_done(gen_done2),
    .gen_count(gen_count2)
  );

  initial ph1 = 1'b0;
  always #5 ph1 = ~ph1;

  typedef struct {
    logic        run;
    logic        step;
    logic [7:0]  nrow;
    logic        e_wr_en;
    logic [2:0]  e_rd1;
    logic [2:0]  e_rd2;
    logic [2:0]  e_rd3;
    logic        e_done;
    logic        e_busy;
    logic        e_bank;
    logic [15:0] e_count;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic [7:0] nr,
                              input logic we, input logic [2:0] a1, input logic [2:0] a2,
                              input logic [2:0] a3, input logic gd, input logic bs,
                              input logic bk, input logic [15:0] cnt);
    vec_t v;
    v.run = r; v.step = s; v.nrow = nr; v.e_wr_en = we;
    v.e_rd1 = a1; v.e_rd2 = a2; v.e_rd3 = a3;
    v.e_done = gd; v.e_busy = bs; v.e_bank = bk; v.e_count = cnt;
    return v;
  endfunction

  // Waits (bounded) for the main instance to go idle, tracking commits.
  task automatic drain(input int budget);
    int c;
    for (c = 0; c < budget; c++) begin
      @(negedge ph1); #1;
      if (gen_done) begin
        exp_bank  = ~exp_bank;
        exp_count = exp_count + 16'd1;
      end
      if (!busy) break;
    end
    check("drain_idle", 32'(busy), 32'd0);
  endtask

  // Free-run with a given period; checks cadence, WAIT length and counters.
  task automatic free_run(input logic [15:0] p, input int interval, input int cycles);
    int last;
    int pulses;
    int stalls;
    int exp_pulses;
    last = -1; pulses = 0; stalls = 0;
    @(negedge ph1);
    run = 1'b1; period = p;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      @(negedge ph1); #1;
      if (busy && !brd.wr_en && !gen_done) stalls++;
      if (gen_done) begin
        check("fr_bank", 32'(bank), 32'(exp_bank));
        check("fr_count", 32'(gen_count), 32'(exp_count));
        if (last >= 0) begin
          check("fr_interval", 32'(cyc - last), 32'(interval));
          check("fr_wait_cycles", 32'(stalls), 32'(p));
        end
        $display("gen_done at cycle %0d: bank=%0d count=%0d", cyc, bank, gen_count);
        stalls = 0; last = cyc; pulses++;
        exp_bank  = ~exp_bank;
        exp_count = exp_count + 16'd1;
      end
    end
    // First commit lands 8 cycles after entering EVAL, then one per interval.
    exp_pulses = (cycles - 1 - 8) / interval + 1;
    check("fr_pulses", 32'(pulses), 32'(exp_pulses));
    run = 1'b0;
    drain(30);
    check("fr_end_bank", 32'(bank), 32'(exp_bank));
    check("fr_end_count", 32'(gen_count), 32'(exp_count));
  endtask

  initial begin
    int i;
    int seen;
    logic found;

    run = 1'b0; step = 1'b0; period = 16'd0; brd.new_row = 8'h00;
    run2 = 1'b0; step2 = 1'b0; period2 = 16'd0; brd2.new_row = 8'h00;
    reset = 1'b0;
    exp_bank = 1'b0; exp_count = 16'd0;

    // Single-step table: idle+step, 8 EVAL rows, COMMIT, two idle cycles.
    vecs[0] = mk(1'b0, 1'b1, 8'h11, 1'b0, 3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 16'd0);
    for (i = 0; i < 8; i++) begin
      vecs[i+1] = mk(1'b0, 1'b0, 8'(8'hA5 ^ (i * 37)), 1'b1,
                     3'((i + 7) % 8), 3'(i), 3'((i + 1) % 8),
                     1'b0, 1'b1, 1'b0, 16'd0);
    end
    vecs[9]  = mk(1'b0, 1'b0, 8'h5A, 1'b0, 3'd7, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 16'd0);
    vecs[10] = mk(1'b0, 1'b0, 8'hC3, 1'b0, 3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'd1);
    vecs[11] = mk(1'b0, 1'b0, 8'h0F, 1'b0, 3'd7, 3'd0, 3'd1, 1'b0, 1'b0, 1'b1, 16'd1);

    // Reset state.
    repeat (3) @(negedge ph1);
    #1;
    check("rst_wr_en", 32'(brd.wr_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_gen_done", 32'(gen_done), 32'd0);
    check("rst_rd_addr1", 32'(brd.rd_addr1), 32'd7);
    check("rst_rd_addr2", 32'(brd.rd_addr2), 32'd0);
    check("rst_rd_addr3", 32'(brd.rd_addr3), 32'd1);
    check("rst_wr_addr", 32'(brd.wr_addr), 32'd0);
    check("rst_bank", 32'(bank), 32'd0);
    check("rst_count", 32'(gen_count), 32'd0);
    reset = 1'b1;

    // Table-driven single step.
    for (int k = 0; k < 12; k++) begin
      @(negedge ph1);
      run = vecs[k].run; step = vecs[k].step; brd.new_row = vecs[k].nrow;
      #1;
      $display("vec %0d: wr_en=%0d rd=(%0d,%0d,%0d) wd=%02h done=%0d busy=%0d bank=%0d count=%0d",
               k, brd.wr_en, brd.rd_addr1, brd.rd_addr2, brd.rd_addr3, brd.wd,
               gen_done, busy, bank, gen_count);
      check("vec_wr_en", 32'(brd.wr_en), 32'(vecs[k].e_wr_en));
      check("vec_rd_addr1", 32'(brd.rd_addr1), 32'(vecs[k].e_rd1));
      check("vec_rd_addr2", 32'(brd.rd_addr2), 32'(vecs[k].e_rd2));
      check("vec_rd_addr3", 32'(brd.rd_addr3), 32'(vecs[k].e_rd3));
      check("vec_wr_addr", 32'(brd.wr_addr), 32'(vecs[k].e_rd2));
      check("vec_wd", 32'(brd.wd), 32'(vecs[k].nrow));
      check("vec_gen_done", 32'(gen_done), 32'(vecs[k].e_done));
      check("vec_busy", 32'(busy), 32'(vecs[k].e_busy));
      check("vec_bank", 32'(bank), 32'(vecs[k].e_bank));
      check("vec_count", 32'(gen_count), 32'(vecs[k].e_count));
    end
    step = 1'b0;
    exp_bank = 1'b1; exp_count = 16'd1;

    // Free-run cadence: 12 cycles with period 3, 9 cycles with period 0.
    free_run(16'd3, 12, 60);
    free_run(16'd0, 9, 60);

    // run dropped at EVAL row 3, with a step during that EVAL.
    @(negedge ph1);
    run = 1'b1; period = 16'd5;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ph1); #1;
      if (brd.wr_en && brd.wr_addr == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("drop_reach_row3", 32'(found), 32'd1);
    run = 1'b0; step = 1'b1;
    for (int k = 4; k < 8; k++) begin
      @(negedge ph1);
      step = 1'b0;
      #1;
      $display("drop: row %0d wr_en=%0d wr_addr=%0d", k, brd.wr_en, brd.wr_addr);
      check("drop_wr_en", 32'(brd.wr_en), 32'd1);
      check("drop_wr_addr", 32'(brd.wr_addr), 32'(k));
    end
    @(negedge ph1); #1;
    check("drop_gen_done", 32'(gen_done), 32'd1);
    check("drop_count_pre", 32'(gen_count), 32'(exp_count));
    exp_bank = ~exp_bank; exp_count = exp_count + 16'd1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge ph1); #1;
      if (gen_done || busy) seen++;
    end
    check("drop_then_idle", 32'(seen), 32'd0);
    check("drop_bank", 32'(bank), 32'(exp_bank));
    check("drop_count", 32'(gen_count), 32'(exp_count));

    // Asynchronous reset mid-run: outputs return to reset values immediately.
    @(negedge ph1);
    run = 1'b1; period = 16'd0;
    repeat (12) @(negedge ph1);
    #2;
    reset = 1'b0;
    #1;
    $display("reset mid-run: busy=%0d wr_en=%0d bank=%0d count=%0d", busy, brd.wr_en, bank, gen_count);
    check("amr_wr_en", 32'(brd.wr_en), 32'd0);
    check("amr_busy", 32'(busy), 32'd0);
    check("amr_gen_done", 32'(gen_done), 32'd0);
    check("amr_rd_addr1", 32'(brd.rd_addr1), 32'd7);
    check("amr_rd_addr2", 32'(brd.rd_addr2), 32'd0);
    check("amr_rd_addr3", 32'(brd.rd_addr3), 32'd1);
    check("amr_wr_addr", 32'(brd.wr_addr), 32'd0);
    check("amr_bank", 32'(bank), 32'd0);
    check("amr_count", 32'(gen_count), 32'd0);
    run = 1'b0;
    @(negedge ph1);
    reset = 1'b1;

    // Narrow counter: 16 single steps wrap 15 -> 0 and bank returns to 0.
    for (int s = 0; s < 16; s++) begin
      @(negedge ph1);
      step2 = 1'b1;
      @(negedge ph1);
      step2 = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge ph1); #1;
        if (!busy2) begin
          found = 1'b1;
          break;
        end
      end
      check("wrap_step_idle", 32'(found), 32'd1);
      $display("narrow step %0d: bank=%0d count=%0d", s + 1, bank2, gen_count2);
      if (s == 14) begin
        check("wrap_count15", 32'(gen_count2), 32'd15);
        check("wrap_bank15", 32'(bank2), 32'd1);
      end
    end
    check("wrap_count0", 32'(gen_count2), 32'd0);
    check("wrap_bank0", 32'(bank2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
